// File: rtl/cache_dram_master.sv
// Cache-side initiator for the word-serial block DRAM protocol: optional victim
// writeback, line refill into a local buffer, one-cycle done pulse to the cache.
module cache_dram_master #(
    parameter int LINE_WORDS = 8,
    parameter int GAP_CYCLES = 4
) (
    input  logic                     clock,
    input  logic                     rst,
    input  logic                     miss_req,
    input  logic [31:0]              miss_addr,
    input  logic                     victim_dirty,
    input  logic                     flush_req,
    input  logic [31:0]              wb_addr,
    input  logic [32*LINE_WORDS-1:0] wb_line,
    output logic                     busy,
    output logic                     done,
    output logic [32*LINE_WORDS-1:0] refill_line,
    output logic                     dram_wr_req,
    output logic [31:0]              dram_wr_addr,
    output logic [31:0]              dram_wr_data,
    input  logic                     dram_wr_val,
    output logic                     dram_rd_req,
    output logic [31:0]              dram_rd_addr,
    input  logic [31:0]              dram_rd_data,
    input  logic                     dram_rd_val
);

    localparam int IW = $clog2(LINE_WORDS);
    localparam int CW = IW + 1;
    localparam int GW = $clog2(GAP_CYCLES + 1);

    localparam logic [31:0]   LINE_MASK = ~(32'(LINE_WORDS) - 32'd1);
    localparam logic [CW-1:0] LAST_WORD = CW'(LINE_WORDS - 1);
    localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WB,
        ST_WB_GAP,
        ST_RD,
        ST_RD_GAP,
        ST_DONE
    } state_t;

    state_t state_q, state_d;

    logic [CW-1:0] wr_cnt_q;
    logic [CW-1:0] rd_cnt_q;
    logic [GW-1:0] gap_cnt_q;
    logic          miss_op_q;
    logic [31:0]   wr_addr_q;
    logic [31:0]   rd_addr_q;

    logic [LINE_WORDS-1:0][31:0] wb_line_q;
    logic [LINE_WORDS-1:0][31:0] refill_q;

    logic wr_last;
    logic rd_last;
    logic gap_last;

    assign wr_last  = (wr_cnt_q == LAST_WORD);
    assign rd_last  = (rd_cnt_q == LAST_WORD);
    assign gap_last = (gap_cnt_q == GAP_LAST);

    assign dram_wr_addr = wr_addr_q;
    assign dram_rd_addr = rd_addr_q;
    assign dram_wr_data = wb_line_q[wr_cnt_q[IW-1:0]];
    assign refill_line  = refill_q;

    always_comb begin
        state_d     = state_q;
        busy        = 1'b0;
        done        = 1'b0;
        dram_wr_req = 1'b0;
        dram_rd_req = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                // miss wins over flush; a coincident flush is dropped
                if (miss_req) begin
                    state_d = victim_dirty ? ST_WB : ST_RD;
                end else if (flush_req) begin
                    state_d = ST_WB;
                end
            end
            ST_WB: begin
                busy = 1'b1;
                // drop the request in the last-word cycle so the controller never restarts
                dram_wr_req = ~(dram_wr_val & wr_last);
                if (dram_wr_val && wr_last) begin
                    state_d = ST_WB_GAP;
                end
            end
            ST_WB_GAP: begin
                busy = 1'b1;
                if (gap_last) begin
                    state_d = miss_op_q ? ST_RD : ST_DONE;
                end
            end
            ST_RD: begin
                busy        = 1'b1;
                dram_rd_req = 1'b1;
                if (dram_rd_val && rd_last) begin
                    state_d = ST_RD_GAP;
                end
            end
            ST_RD_GAP: begin
                busy = 1'b1;
                if (gap_last) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            wr_cnt_q  <= '0;
            rd_cnt_q  <= '0;
            miss_op_q <= 1'b0;
            wr_addr_q <= '0;
            rd_addr_q <= '0;
            wb_line_q <= '0;
            refill_q  <= '0;
        end else begin
            state_q <= state_d;
            unique case (state_q)
                ST_IDLE: begin
                    if (miss_req || flush_req) begin
                        miss_op_q <= miss_req;
                        wr_addr_q <= wb_addr & LINE_MASK;
                        rd_addr_q <= miss_addr & LINE_MASK;
                        wb_line_q <= wb_line;
                        wr_cnt_q  <= '0;
                        rd_cnt_q  <= '0;
                    end
                end
                ST_WB: begin
                    if (dram_wr_val) begin
                        wr_cnt_q <= wr_cnt_q + CW'(1);
                    end
                end
                ST_RD: begin
                    if (dram_rd_val) begin
                        refill_q[rd_cnt_q[IW-1:0]] <= dram_rd_data;
                        rd_cnt_q                   <= rd_cnt_q + CW'(1);
                    end
                end
                ST_DONE: begin
                    wr_cnt_q <= '0;
                    rd_cnt_q <= '0;
                end
                default: begin
                end
            endcase
        end
    end

    // Post-block spacing: counts GAP_CYCLES in either gap state, idles at zero elsewhere
    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            gap_cnt_q <= '0;
        end else if ((state_q == ST_WB_GAP) || (state_q == ST_RD_GAP)) begin
            gap_cnt_q <= gap_last ? '0 : gap_cnt_q + GW'(1);
        end else begin
            gap_cnt_q <= '0;
        end
    end

endmodule

// File: tb/tb_cache_dram_master.sv
// Bench for cache_dram_master: a behavioural DRAM controller with random word
// spacing, a line-level reference model, and directed plus randomized operations.
module tb_cache_dram_master;

    localparam int LW  = 8;
    localparam int GAP = 4;
    localparam logic [31:0] MASK = 32'hFFFF_FFF8;

    logic                clock;
    logic                rst;
    logic                miss_req;
    logic [31:0]         miss_addr;
    logic                victim_dirty;
    logic                flush_req;
    logic [31:0]         wb_addr;
    logic [32*LW-1:0]    wb_line;
    logic                busy;
    logic                done;
    logic [32*LW-1:0]    refill_line;
    logic                dram_wr_req;
    logic [31:0]         dram_wr_addr;
    logic [31:0]         dram_wr_data;
    logic                dram_wr_val;
    logic                dram_rd_req;
    logic [31:0]         dram_rd_addr;
    logic [31:0]         dram_rd_data;
    logic                dram_rd_val;

    cache_dram_master #(.LINE_WORDS(LW), .GAP_CYCLES(GAP)) dut (
        .clock        (clock),
        .rst          (rst),
        .miss_req     (miss_req),
        .miss_addr    (miss_addr),
        .victim_dirty (victim_dirty),
        .flush_req    (flush_req),
        .wb_addr      (wb_addr),
        .wb_line      (wb_line),
        .busy         (busy),
        .done         (done),
        .refill_line  (refill_line),
        .dram_wr_req  (dram_wr_req),
        .dram_wr_addr (dram_wr_addr),
        .dram_wr_data (dram_wr_data),
        .dram_wr_val  (dram_wr_val),
        .dram_rd_req  (dram_rd_req),
        .dram_rd_addr (dram_rd_addr),
        .dram_rd_data (dram_rd_data),
        .dram_rd_val  (dram_rd_val)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed=no_finish required=finish");
        $fatal(1, "watchdog expired");
    end

    int total = 0;
    int bad   = 0;

    // DRAM contents: unwritten words read back as 0xA000_0000 + address
    logic [31:0] mem [logic [31:0]];
    logic [31:0] exp_refill [LW];

    int          rd_vals = 0, rd_blocks = 0, wr_blocks = 0;
    logic [31:0] last_rd_addr = '0, last_wr_addr = '0;
    logic        wr_req_at_last = 1'b0, rd_req_after_last = 1'b0;
    int          inject_req = 0, inject_ack = 0;

    int   cyc = 0, done_count = 0, done_cyc = 0, last_rd_val_cyc = 0;
    int   overlap = 0, wr_req_cycles = 0, low_run = 0, last_low_run = 0;
    logic prev_rd_req = 1'b0;

    function automatic logic [31:0] dram_word(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return 32'hA000_0000 + a;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // ---------------- DRAM controller model ----------------
    task automatic tick(output bit ab);
        @(posedge clock);
        #1;
        ab = !rst;
        if (ab) begin
            dram_wr_val = 1'b0;
            dram_rd_val = 1'b0;
        end
    endtask

    task automatic serve_write();
        logic [31:0] a;
        bit ab;
        a = dram_wr_addr;
        last_wr_addr = a;
        wr_blocks++;
        tick(ab);
        if (ab) return;
        for (int k = 0; k < LW; k++) begin
            repeat ($urandom_range(2, 0)) begin
                tick(ab);
                if (ab) return;
            end
            dram_wr_val = 1'b1;
            @(negedge clock);
            mem[a + 32'(k)] = dram_wr_data;
            if (k == LW - 1) wr_req_at_last = dram_wr_req;
            tick(ab);
            dram_wr_val = 1'b0;
            if (ab) return;
        end
    endtask

    task automatic serve_read();
        logic [31:0] a;
        bit ab;
        a = dram_rd_addr;
        last_rd_addr = a;
        rd_blocks++;
        tick(ab);
        if (ab) return;
        for (int k = 0; k < LW; k++) begin
            repeat ($urandom_range(2, 0)) begin
                tick(ab);
                if (ab) return;
            end
            dram_rd_data = dram_word(a + 32'(k));
            dram_rd_val  = 1'b1;
            rd_vals++;
            tick(ab);
            dram_rd_val = 1'b0;
            if (ab) return;
            if (k == LW - 1) rd_req_after_last = dram_rd_req;
        end
    endtask

    initial begin
        dram_wr_val  = 1'b0;
        dram_rd_val  = 1'b0;
        dram_rd_data = '0;
        forever begin
            @(posedge clock);
            #1;
            if (!rst) continue;
            if (inject_req != inject_ack) begin
                inject_ack   = inject_req;
                dram_wr_val  = 1'b1;
                dram_rd_val  = 1'b1;
                dram_rd_data = 32'hDEAD_BEEF;
                @(posedge clock);
                #1;
                dram_wr_val = 1'b0;
                dram_rd_val = 1'b0;
            end else if (dram_wr_req) begin
                serve_write();
            end else if (dram_rd_req) begin
                serve_read();
            end
        end
    end

    // ---------------- cycle monitor ----------------
    initial begin
        forever begin
            @(negedge clock);
            cyc++;
            if (dram_wr_req && dram_rd_req) overlap++;
            if (dram_wr_req) wr_req_cycles++;
            if (done) begin
                done_count++;
                done_cyc = cyc;
            end
            if (dram_rd_val) last_rd_val_cyc = cyc;
            if (dram_rd_req) begin
                if (!prev_rd_req) last_low_run = low_run;
                low_run = 0;
            end else begin
                low_run++;
            end
            prev_rd_req = dram_rd_req;
        end
    end

    // ---------------- helpers ----------------
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (done !== 1'b1 && n < 400);
        check({tag, "_done_seen"}, 32'(done), 32'd1);
        check({tag, "_busy_at_done"}, 32'(busy), 32'd0);
    endtask

    task automatic check_refill(input string tag, input logic [31:0] base);
        for (int k = 0; k < LW; k++) begin
            exp_refill[k] = dram_word(base + 32'(k));
            check($sformatf("%s_refill_w%0d", tag, k), refill_line[32*k +: 32], exp_refill[k]);
        end
    endtask

    task automatic check_refill_held(input string tag);
        for (int k = 0; k < LW; k++)
            check($sformatf("%s_held_w%0d", tag, k), refill_line[32*k +: 32], exp_refill[k]);
    endtask

    function automatic logic [32*LW-1:0] rand_line();
        logic [32*LW-1:0] l;
        for (int k = 0; k < LW; k++) l[32*k +: 32] = $urandom();
        return l;
    endfunction

    task automatic run_op(input string tag, input bit is_miss, input bit dirty,
                          input logic [31:0] maddr, input logic [31:0] waddr,
                          input logic [32*LW-1:0] line);
        int wb0, rb0, dc0, wc0;
        logic [31:0] mb, wbase;
        mb    = maddr & MASK;
        wbase = waddr & MASK;
        step();
        wb0 = wr_blocks; rb0 = rd_blocks; dc0 = done_count; wc0 = wr_req_cycles;
        miss_addr    = maddr;
        wb_addr      = waddr;
        wb_line      = line;
        victim_dirty = dirty;
        miss_req     = is_miss;
        flush_req    = !is_miss;
        step();
        miss_req  = 1'b0;
        flush_req = 1'b0;
        check({tag, "_busy"}, 32'(busy), 32'd1);
        wait_done(tag);
        @(negedge clock);
        check({tag, "_done_pulse"}, 32'(done), 32'd0);
        if (is_miss) begin
            check_refill(tag, mb);
            check({tag, "_rd_addr"}, last_rd_addr, mb);
            check({tag, "_rd_req_after_last"}, 32'(rd_req_after_last), 32'd0);
            check({tag, "_done_latency"}, 32'(done_cyc - last_rd_val_cyc), 32'(GAP + 1));
        end else begin
            check_refill_held(tag);
        end
        if (is_miss && !dirty) begin
            check({tag, "_no_wr_req"}, 32'(wr_req_cycles - wc0), 32'd0);
        end else begin
            check({tag, "_wr_addr"}, last_wr_addr, wbase);
            check({tag, "_wr_req_last"}, 32'(wr_req_at_last), 32'd0);
            for (int k = 0; k < LW; k++)
                check($sformatf("%s_mem_w%0d", tag, k), dram_word(wbase + 32'(k)), line[32*k +: 32]);
        end
        step();
        step();
        check({tag, "_done_count"}, 32'(done_count - dc0), 32'd1);
        check({tag, "_wr_blocks"}, 32'(wr_blocks - wb0), (is_miss && !dirty) ? 32'd0 : 32'd1);
        check({tag, "_rd_blocks"}, 32'(rd_blocks - rb0), is_miss ? 32'd1 : 32'd0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        logic [32*LW-1:0] line;
        logic [31:0] a_addr, b_addr;
        int dc0, rb0, wb0, rv0, n;

        rst = 1'b1; miss_req = 1'b0; flush_req = 1'b0; victim_dirty = 1'b0;
        miss_addr = '0; wb_addr = '0; wb_line = '0;
        #3 rst = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_wr_req", 32'(dram_wr_req), 32'd0);
        check("rst_rd_req", 32'(dram_rd_req), 32'd0);
        check("rst_wr_addr", dram_wr_addr, 32'd0);
        check("rst_rd_addr", dram_rd_addr, 32'd0);
        check("rst_wr_data", dram_wr_data, 32'd0);
        for (int k = 0; k < LW; k++) exp_refill[k] = '0;
        check_refill_held("rst");
        @(negedge clock);
        rst = 1'b1;

        // clean miss: words 0xA000_0100..0xA000_0107
        run_op("clean", 1'b1, 1'b0, 32'h105, 32'h0, '0);
        check("clean_w7", refill_line[32*7 +: 32], 32'hA000_0107);

        // dirty miss: victim 0xB0..0xB7 to 0x40, refill 0x80
        for (int k = 0; k < LW; k++) line[32*k +: 32] = 32'hB0 + 32'(k);
        run_op("dirty", 1'b1, 1'b1, 32'h80, 32'h40, line);

        // flush to 0x200: refill must stay as the dirty miss left it
        run_op("flush", 1'b0, 1'b0, $urandom() & 32'hFFFF, 32'h203, rand_line());

        // contention: miss and flush together, then a miss raised while busy
        a_addr = $urandom() & 32'hFFFF;
        step();
        dc0 = done_count; rb0 = rd_blocks; wb0 = wr_blocks;
        miss_addr = a_addr; wb_addr = 32'h300; wb_line = rand_line();
        victim_dirty = 1'b0; miss_req = 1'b1; flush_req = 1'b1;
        step();
        miss_req = 1'b0; flush_req = 1'b0;
        step(); step();
        miss_addr = a_addr ^ 32'h0000_8000; miss_req = 1'b1;
        step(); step();
        miss_req = 1'b0;
        wait_done("cont");
        check_refill("cont", a_addr & MASK);
        repeat (20) step();
        check("cont_done_count", 32'(done_count - dc0), 32'd1);
        check("cont_rd_blocks", 32'(rd_blocks - rb0), 32'd1);
        check("cont_wr_blocks", 32'(wr_blocks - wb0), 32'd0);
        check("cont_idle", 32'(busy), 32'd0);

        // spurious strobes while idle, then a dirty miss that depends on clean counters
        step();
        inject_req++;
        repeat (4) step();
        check("spur_busy", 32'(busy), 32'd0);
        check_refill_held("spur");
        run_op("spur_miss", 1'b1, 1'b1, $urandom() & 32'hFFFF, $urandom() & 32'hFFFF, rand_line());

        // reset asserted after the third read word
        step();
        rv0 = rd_vals;
        miss_addr = $urandom() & 32'hFFFF; victim_dirty = 1'b0; miss_req = 1'b1;
        step();
        miss_req = 1'b0;
        n = 0;
        while ((rd_vals - rv0) < 3 && n < 300) begin
            @(negedge clock);
            n++;
        end
        check("rstmid_3vals", 32'((rd_vals - rv0) >= 3), 32'd1);
        @(posedge clock);
        #2 rst = 1'b0;
        #1;
        check("rstmid_busy", 32'(busy), 32'd0);
        check("rstmid_done", 32'(done), 32'd0);
        check("rstmid_rd_req", 32'(dram_rd_req), 32'd0);
        check("rstmid_wr_req", 32'(dram_wr_req), 32'd0);
        check("rstmid_rd_addr", dram_rd_addr, 32'd0);
        for (int k = 0; k < LW; k++) exp_refill[k] = '0;
        check_refill_held("rstmid");
        repeat (3) @(posedge clock);
        @(negedge clock);
        rst = 1'b1;
        run_op("post_rst", 1'b1, 1'b0, $urandom() & 32'hFFFF, 32'h0, '0);

        // back-to-back misses with miss_req held through done
        a_addr = $urandom() & 32'hFFFF;
        b_addr = a_addr + 32'h100;
        step();
        miss_addr = a_addr; victim_dirty = 1'b0; miss_req = 1'b1;
        step();
        miss_addr = b_addr;
        wait_done("b2b1");
        check_refill("b2b1", a_addr & MASK);
        @(negedge clock);
        check("b2b_idle_after_done", 32'(busy), 32'd0);
        @(negedge clock);
        check("b2b_accepted", 32'(busy), 32'd1);
        step();
        miss_req = 1'b0;
        wait_done("b2b2");
        check_refill("b2b2", b_addr & MASK);
        check("b2b_rd_addr", last_rd_addr, b_addr & MASK);
        check("b2b_rd_gap", 32'(last_low_run >= GAP + 1), 32'd1);

        repeat (4) step();
        check("never_both_req", 32'(overlap), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
